vga_timing_gen: RTL
===================

# vga_timing_gen

Parametrised VGA raster timing generator and pixel output stage; successor to the fixed 640x480, 8-bit VGA interface. Generates horizontal and vertical counters, sync pulses of configurable polarity, a data-enable, and a frame-start strobe, and presents framebuffer addresses. It also samples incoming colour and blanks it outside the active area. Sits between the framebuffer/colour source and the VGA connector; the pixel rate is derived from the system clock by an integer divider.

## Interface

- COLOUR_W, 8: colour bus width.
- ADDR_W, 10: address/counter width; must hold H_TOTAL-1 and V_TOTAL-1.
- H_ACTIVE, 640 / H_FP, 16 / H_SYNC, 96 / H_BP, 48: horizontal region lengths in pixel ticks.
- V_ACTIVE, 480 / V_FP, 10 / V_SYNC, 2 / V_BP, 33: vertical region lengths in lines.
- HS_POL, 0 / VS_POL, 0: asserted sync level (0 = active-low).
- CLK_DIV, 2: CLK cycles per pixel tick, ≥1.

- CLK  in  1  system clock, single clock domain.
- RESETn  in  1  asynchronous, active-low reset.
- EN  in  1  scan enable; low holds the block in its reset state.
- COLOUR_IN  in  COLOUR_W  colour of pixel (addrh, addrv); valid at the tick edge.
- cout  out  COLOUR_W  colour to DAC; 0 during blanking.
- hs / vs  out  1  horizontal / vertical sync.
- de  out  1  active-video flag aligned with cout.
- addrh / addrv  out  ADDR_W  current raster counter (pixel to fetch).
- frame_start  out  1  one-CLK pulse when pixel (0,0) appears on cout.

## Operation

- Divider `div` counts 0..CLK_DIV-1; tick = (div == CLK_DIV-1). CLK_DIV=1 gives a tick every cycle.
- On tick: if h == H_TOTAL-1, h←0 and v←(v == V_TOTAL-1 ? 0 : v+1); else h←h+1. H_TOTAL = sum of the four H lengths; V_TOTAL likewise.
- addrh = h, addrv = v, driven directly from the counter registers.
- Registered on tick, from pre-update h, v:
  - de ← (h < H_ACTIVE && v < V_ACTIVE).
  - cout ← that condition ? COLOUR_IN : 0.
  - hs ← HS_POL when H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL.
  - vs ← VS_POL over the same window on v, for whole lines; else ~VS_POL.
  - frame_start ← (h == 0 && v == 0) on the tick, and is forced to 0 on the following CLK.
- Between ticks, all outputs except frame_start hold.
- EN low, sampled each CLK: at the next edge, div, h and v clear and outputs take reset values. Scanning resumes from (0,0) on EN rise.
- Reset values (RESETn low, asynchronous): div=h=v=0, addrh=addrv=0, cout=0, de=0, frame_start=0, hs=~HS_POL, vs=~VS_POL.

## Timing

- Address-to-colour latency: one pixel tick. The address in tick period k has its colour, de, hs and vs on the outputs in period k+1.
- COLOUR_IN must be stable at the tick edge, so the source is combinational or pre-fetched one tick ahead.
- Line period: H_TOTAL ticks = H_TOTAL·CLK_DIV CLKs. Frame period: V_TOTAL lines.
- Wrap-around (h=H_TOTAL-1, v=V_TOTAL-1): both counters return to 0 on the same tick; there is no idle tick.
- RESETn deassertion is synchronous to the design; the first tick occurs CLK_DIV edges after release.

## Structure

- Package vga_pkg:
  - Default 640x480@60 timing constants.
  - Derived H_TOTAL, V_TOTAL, sync start/end localparams.
  - Polarity constants.
- Sub-module vga_sync_counter, instantiated twice (horizontal stepping on tick, vertical stepping on the horizontal wrap):
  - Parameters: ACTIVE, FP, SYNC, BP, POL.
  - Outputs: count, wrap, active, sync.
- Top level holds the divider, EN handling and the output registers.

## Test plan

- Reset: RESETn=0 mid-frame → immediately cout=0, de=0, hs=vs=1, addrh=addrv=0, frame_start=0.
- Defaults, EN=1, COLOUR_IN=8'hFF:
  - hs low for exactly 192 CLKs, first fall one tick after h=656.
  - Line period 1600 CLKs.
  - de high 1280 CLKs per line; cout=8'hFF only while de, else 0.
- Defaults: vs low for 2 lines starting at line 490; frame period 525·800 ticks; de in 480 lines per frame.
- Small config (H 4/1/2/1, V 3/1/1/1, CLK_DIV=1, HS_POL=1):
  - h wraps 7→0 and v increments on that tick; v wraps 5→0.
  - frame_start pulses every 48 CLKs; hs high for h∈{5,6}, delayed by one tick.
- Latency: drive COLOUR_IN = addrh[7:0] → cout equals the previous tick's addrh during active video.
- EN dropped mid-line for 10 CLKs → outputs at reset values from the next edge; after EN rise, addrh counts 0,1,2… and the first frame_start follows the first tick.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing constants: default 640x480@60 raster, derived totals and
// sync windows, polarity encodings and a sync-level helper.
package vga_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int DEF_H_TOTAL      = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL      = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int DEF_H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
  localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC;
  localparam int DEF_V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
  localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC;

  localparam logic POL_ACTIVE_LOW  = 1'b0;
  localparam logic POL_ACTIVE_HIGH = 1'b1;

  // Level driven on a sync line: the asserted polarity inside the window,
  // its complement everywhere else.
  function automatic logic sync_level(input logic in_window, input logic pol);
    return in_window ? pol : ~pol;
  endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// One raster axis: counts 0..TOTAL-1 on each step and decodes wrap,
// active-region and sync-window flags from the current count.
module vga_sync_counter
  import vga_pkg::*;
#(
  parameter int   ADDR_W = 10,
  parameter int   ACTIVE = DEF_H_ACTIVE,
  parameter int   FP     = DEF_H_FP,
  parameter int   SYNC   = DEF_H_SYNC,
  parameter int   BP     = DEF_H_BP,
  parameter logic POL    = POL_ACTIVE_LOW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              step,
  output logic [ADDR_W-1:0] count,
  output logic              wrap,
  output logic              active,
  output logic              sync
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;

  localparam logic [ADDR_W-1:0] LAST       = ADDR_W'(TOTAL - 1);
  localparam logic [ADDR_W-1:0] ACT_END    = ADDR_W'(ACTIVE);
  localparam logic [ADDR_W-1:0] SYNC_START = ADDR_W'(ACTIVE + FP);
  localparam logic [ADDR_W-1:0] SYNC_END   = ADDR_W'(ACTIVE + FP + SYNC);

  assign wrap   = (count == LAST);
  assign active = (count < ACT_END);
  assign sync   = sync_level((count >= SYNC_START) && (count < SYNC_END), POL);

  // Counter advances on step and returns to zero after the last position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (step) begin
      count <= wrap ? '0 : count + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-tick divider, horizontal/vertical
// counters and a registered output stage that blanks colour outside the
// active area. Outputs lag the presented address by one pixel tick.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   COLOUR_W = 8,
  parameter int   ADDR_W   = 10,
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic HS_POL   = POL_ACTIVE_LOW,
  parameter logic VS_POL   = POL_ACTIVE_LOW,
  parameter int   CLK_DIV  = 2
) (
  input  logic                CLK,
  input  logic                RESETn,
  input  logic                EN,
  input  logic [COLOUR_W-1:0] COLOUR_IN,
  output logic [COLOUR_W-1:0] cout,
  output logic                hs,
  output logic                vs,
  output logic                de,
  output logic [ADDR_W-1:0]   addrh,
  output logic [ADDR_W-1:0]   addrv,
  output logic                frame_start
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div;
  logic             tick;
  logic             h_wrap, h_active, h_sync;
  logic             v_wrap_unused, v_active, v_sync;
  logic             de_p0;
  logic             origin_p0;

  assign tick = (div == DIV_LAST);

  // Pixel-tick divider; held at zero while scanning is disabled.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      div <= '0;
    end else if (!EN || tick) begin
      div <= '0;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  vga_sync_counter #(
    .ADDR_W (ADDR_W),
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (HS_POL)
  ) u_hcnt (
    .clk    (CLK),
    .rst_n  (RESETn),
    .clr    (!EN),
    .step   (tick),
    .count  (addrh),
    .wrap   (h_wrap),
    .active (h_active),
    .sync   (h_sync)
  );

  // Vertical position only moves on the tick that ends a line.
  vga_sync_counter #(
    .ADDR_W (ADDR_W),
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (VS_POL)
  ) u_vcnt (
    .clk    (CLK),
    .rst_n  (RESETn),
    .clr    (!EN),
    .step   (tick && h_wrap),
    .count  (addrv),
    .wrap   (v_wrap_unused),
    .active (v_active),
    .sync   (v_sync)
  );

  // Stage p0: decode of the pixel currently addressed (pre-update counters).
  assign de_p0     = h_active && v_active;
  assign origin_p0 = (addrh == '0) && (addrv == '0);

  // Stage p1: output register, loaded on each tick; frame_start lasts one CLK.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      cout        <= '0;
      de          <= 1'b0;
      hs          <= ~HS_POL;
      vs          <= ~VS_POL;
      frame_start <= 1'b0;
    end else if (!EN) begin
      cout        <= '0;
      de          <= 1'b0;
      hs          <= ~HS_POL;
      vs          <= ~VS_POL;
      frame_start <= 1'b0;
    end else begin
      frame_start <= tick && origin_p0;
      if (tick) begin
        de   <= de_p0;
        cout <= de_p0 ? COLOUR_IN : '0;
        hs   <= h_sync;
        vs   <= v_sync;
      end
    end
  end

endmodule
